// File: rtl/ar_channel_arbiter.sv
// Two-source arbiter for the DDR AR channel: demand reads have priority, and a
// programmable starvation counter guarantees that prefetch reads make progress.
module ar_channel_arbiter #(
    parameter int unsigned ADDR_BITS         = 16,
    parameter int unsigned BURST_LEN_WIDTH   = 8,
    parameter int unsigned TID_WIDTH         = 8,
    parameter int unsigned PRFETCH_FRQ_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         en,
    input  logic                         flush,
    input  logic [PRFETCH_FRQ_WIDTH-1:0] crs_prefetch_freq,
    input  logic                         dmd_valid,
    output logic                         dmd_ready,
    input  logic [ADDR_BITS-1:0]         dmd_addr,
    input  logic [BURST_LEN_WIDTH-1:0]   dmd_len,
    input  logic [TID_WIDTH-1:0]         dmd_id,
    input  logic                         pf_valid,
    output logic                         pf_ready,
    input  logic [ADDR_BITS-1:0]         pf_addr,
    input  logic [BURST_LEN_WIDTH-1:0]   pf_len,
    input  logic [TID_WIDTH-1:0]         pf_id,
    output logic                         m_ar_valid,
    input  logic                         m_ar_ready,
    output logic [ADDR_BITS-1:0]         m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]   m_ar_len,
    output logic [TID_WIDTH-1:0]         m_ar_id,
    output logic                         m_ar_src,
    output logic [PRFETCH_FRQ_WIDTH-1:0] starveCnt
);

    localparam logic [PRFETCH_FRQ_WIDTH-1:0] CNT_ONE = PRFETCH_FRQ_WIDTH'(1);
    localparam logic [PRFETCH_FRQ_WIDTH-1:0] CNT_MAX = '1;

    logic                         r_valid;
    logic [ADDR_BITS-1:0]         r_addr;
    logic [BURST_LEN_WIDTH-1:0]   r_len;
    logic [TID_WIDTH-1:0]         r_id;
    logic                         r_src;
    logic [PRFETCH_FRQ_WIDTH-1:0] r_starve_cnt;

    logic w_load;
    logic w_pf_elig;
    logic w_starved;
    logic w_grant_pf;
    logic w_grant_dmd;

    // A grant is only taken when the output register is empty or draining this cycle.
    always_comb begin
        w_load      = !r_valid || m_ar_ready;
        w_pf_elig   = pf_valid && en && !flush;
        w_starved   = (r_starve_cnt >= crs_prefetch_freq);
        w_grant_pf  = w_load && w_pf_elig && (!dmd_valid || w_starved);
        w_grant_dmd = w_load && dmd_valid && !w_grant_pf;
    end

    assign dmd_ready = resetN && w_grant_dmd;
    assign pf_ready  = resetN && w_grant_pf;

    // One-entry AR output stage; fields only change on a new grant.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_id    <= '0;
            r_src   <= 1'b0;
        end else if (w_grant_pf) begin
            r_valid <= 1'b1;
            r_addr  <= pf_addr;
            r_len   <= pf_len;
            r_id    <= pf_id;
            r_src   <= 1'b1;
        end else if (w_grant_dmd) begin
            r_valid <= 1'b1;
            r_addr  <= dmd_addr;
            r_len   <= dmd_len;
            r_id    <= dmd_id;
            r_src   <= 1'b0;
        end else if (m_ar_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Counts demand grants that bypassed an eligible prefetch.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_starve_cnt <= '0;
        end else if (w_grant_pf) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dmd && w_pf_elig && (r_starve_cnt != CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + CNT_ONE;
        end
    end

    assign m_ar_valid = r_valid;
    assign m_ar_addr  = r_addr;
    assign m_ar_len   = r_len;
    assign m_ar_id    = r_id;
    assign m_ar_src   = r_src;
    assign starveCnt  = r_starve_cnt;

endmodule
